// File: rtl/cache_pkg.sv
// Shared definitions for the cache controller slice.
// Holds the address/data geometry of the 2-way, 32-set cache array, the
// controller state encoding and the captured CPU request record.
package cache_pkg;

    localparam int ADDR_W = 14;
    localparam int DATA_W = 64;
    localparam int IDX_W  = 5;
    localparam int TAG_W  = ADDR_W - IDX_W;

    typedef enum logic [2:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE,
        FILL
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    // Request captured in IDLE and held for the whole transaction.
    typedef struct packed {
        op_t               op;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } req_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the hit/miss statistics.
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   inc      : count up by one this cycle (ignored once at all-ones)
//   clear    : synchronous return to zero, has priority over inc
//   count    : current count value
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clear,
    output logic [CNT_W-1:0] count
);

    // Holds at all-ones instead of wrapping so a long run never reads as small.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/cache_ctrl_fsm.sv
// Initiator-side controller for the 2-way, 32-set, one-word-per-line cache.
// Takes level CPU read/write requests, looks them up in the array, writes
// back a dirty victim, fetches a missing line for reads and fills the array.
// Ports:
//   clk, rst                     : clock, asynchronous active-high reset
//   cpu_re/we/addr/wr_data       : CPU request, held until cpu_rdy
//   cpu_rd_data, cpu_rdy         : read return data and one-cycle completion
//   c_addr/wr_data/wdirty/we/re/toggle : array control
//   c_rd_data/tag_out/hit/dirty  : array lookup results
//   mem_re/we/addr/wr_data       : main-memory request, held until mem_rdy
//   mem_rd_data, mem_rdy         : main-memory response
//   hit_cnt, miss_cnt            : saturating statistics
module cache_ctrl_fsm
    import cache_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_re,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wr_data,
    output logic [DATA_W-1:0] cpu_rd_data,
    output logic              cpu_rdy,
    output logic [ADDR_W-1:0] c_addr,
    output logic [DATA_W-1:0] c_wr_data,
    output logic              c_wdirty,
    output logic              c_we,
    output logic              c_re,
    output logic              c_toggle,
    input  logic [DATA_W-1:0] c_rd_data,
    input  logic [TAG_W-1:0]  c_tag_out,
    input  logic              c_hit,
    input  logic              c_dirty,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    input  logic              mem_rdy,
    output logic [CNT_W-1:0]  hit_cnt,
    output logic [CNT_W-1:0]  miss_cnt
);

    state_t state;
    req_t   req;
    logic   hit_inc;
    logic   miss_inc;

    // Statistics are taken from the lookup cycle, when the array answers.
    assign hit_inc  = (state == COMPARE) && c_hit;
    assign miss_inc = (state == COMPARE) && !c_hit;

    sat_counter #(.CNT_W(CNT_W)) u_hit_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (hit_inc),
        .clear (1'b0),
        .count (hit_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_miss_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (miss_inc),
        .clear (1'b0),
        .count (miss_cnt)
    );

    // All outputs are registered: each state's strobes are loaded on the edge
    // that enters it, so they are high for exactly the cycles spent there.
    // Array strobes and cpu_rdy default low every cycle; memory strobes are
    // held until mem_rdy. mem_addr/mem_wr_data double as the victim latch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            req         <= '0;
            cpu_rd_data <= '0;
            cpu_rdy     <= 1'b0;
            c_addr      <= '0;
            c_wr_data   <= '0;
            c_wdirty    <= 1'b0;
            c_we        <= 1'b0;
            c_re        <= 1'b0;
            c_toggle    <= 1'b0;
            mem_re      <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wr_data <= '0;
        end else begin
            cpu_rdy  <= 1'b0;
            c_we     <= 1'b0;
            c_re     <= 1'b0;
            c_toggle <= 1'b0;
            c_wdirty <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cpu_re || cpu_we) begin
                        req.op   <= cpu_we ? OP_WRITE : OP_READ;
                        req.addr <= cpu_addr;
                        req.data <= cpu_wr_data;
                        c_re     <= 1'b1;
                        c_addr   <= cpu_addr;
                        state    <= COMPARE;
                    end
                end
                COMPARE: begin
                    if (c_hit) begin
                        if (req.op == OP_READ) begin
                            cpu_rd_data <= c_rd_data;
                            cpu_rdy     <= 1'b1;
                            state       <= IDLE;
                        end else begin
                            // Write hit rewrites the line in place, LRU untouched.
                            c_we      <= 1'b1;
                            c_addr    <= req.addr;
                            c_wr_data <= req.data;
                            c_wdirty  <= 1'b1;
                            state     <= FILL;
                        end
                    end else if (c_dirty) begin
                        mem_we      <= 1'b1;
                        mem_addr    <= {c_tag_out, req.addr[IDX_W-1:0]};
                        mem_wr_data <= c_rd_data;
                        state       <= WRITEBACK;
                    end else if (req.op == OP_READ) begin
                        mem_re   <= 1'b1;
                        mem_addr <= req.addr;
                        state    <= ALLOCATE;
                    end else begin
                        // A write covers the whole line, so nothing to fetch.
                        c_we      <= 1'b1;
                        c_addr    <= req.addr;
                        c_wr_data <= req.data;
                        c_wdirty  <= 1'b1;
                        c_toggle  <= 1'b1;
                        state     <= FILL;
                    end
                end
                WRITEBACK: begin
                    if (mem_rdy) begin
                        mem_we <= 1'b0;
                        if (req.op == OP_READ) begin
                            mem_re   <= 1'b1;
                            mem_addr <= req.addr;
                            state    <= ALLOCATE;
                        end else begin
                            c_we      <= 1'b1;
                            c_addr    <= req.addr;
                            c_wr_data <= req.data;
                            c_wdirty  <= 1'b1;
                            c_toggle  <= 1'b1;
                            state     <= FILL;
                        end
                    end
                end
                ALLOCATE: begin
                    if (mem_rdy) begin
                        mem_re    <= 1'b0;
                        c_we      <= 1'b1;
                        c_addr    <= req.addr;
                        c_wr_data <= mem_rd_data;
                        c_toggle  <= 1'b1;
                        state     <= FILL;
                    end
                end
                FILL: begin
                    // c_wr_data still holds the fetched line for read misses.
                    cpu_rdy <= 1'b1;
                    if (req.op == OP_READ) begin
                        cpu_rd_data <= c_wr_data;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cache_ctrl_fsm.sv
// Self-checking bench for cache_ctrl_fsm: a behavioural array/memory model,
// scoreboard queues for fills, memory requests and CPU completions, and one
// task per scenario. A second instance with 4-bit counters covers saturation.
module tb_cache_ctrl_fsm;
    import cache_pkg::*;

    localparam int MEM_WAIT = 3;

    logic              clk, rst;
    logic              cpu_re, cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wr_data, cpu_rd_data;
    logic              cpu_rdy;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wr_data, c_rd_data;
    logic              c_wdirty, c_we, c_re, c_toggle;
    logic [TAG_W-1:0]  c_tag_out;
    logic              c_hit, c_dirty;
    logic              mem_re, mem_we, mem_rdy;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wr_data, mem_rd_data;
    logic [15:0]       hit_cnt, miss_cnt;

    logic [DATA_W-1:0] s_cpu_rd_data, s_c_wr_data, s_mem_wr_data;
    logic [ADDR_W-1:0] s_c_addr, s_mem_addr;
    logic              s_cpu_rdy, s_c_wdirty, s_c_we, s_c_re, s_c_toggle, s_mem_re, s_mem_we;
    logic [3:0]        s_hit_cnt, s_miss_cnt;

    cache_ctrl_fsm #(.CNT_W(16)) dut (
        .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_rd_data(cpu_rd_data), .cpu_rdy(cpu_rdy),
        .c_addr(c_addr), .c_wr_data(c_wr_data), .c_wdirty(c_wdirty), .c_we(c_we),
        .c_re(c_re), .c_toggle(c_toggle), .c_rd_data(c_rd_data), .c_tag_out(c_tag_out),
        .c_hit(c_hit), .c_dirty(c_dirty), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
        .mem_rdy(mem_rdy), .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    cache_ctrl_fsm #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .cpu_re(cpu_re), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wr_data(cpu_wr_data), .cpu_rd_data(s_cpu_rd_data), .cpu_rdy(s_cpu_rdy),
        .c_addr(s_c_addr), .c_wr_data(s_c_wr_data), .c_wdirty(s_c_wdirty), .c_we(s_c_we),
        .c_re(s_c_re), .c_toggle(s_c_toggle), .c_rd_data(c_rd_data), .c_tag_out(c_tag_out),
        .c_hit(c_hit), .c_dirty(c_dirty), .mem_re(s_mem_re), .mem_we(s_mem_we),
        .mem_addr(s_mem_addr), .mem_wr_data(s_mem_wr_data), .mem_rd_data(mem_rd_data),
        .mem_rdy(mem_rdy), .hit_cnt(s_hit_cnt), .miss_cnt(s_miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { bit is_read; logic [DATA_W-1:0] data; } rdy_exp_t;
    typedef struct { logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; bit wdirty; bit toggle; } fill_exp_t;
    typedef struct { bit we; logic [ADDR_W-1:0] addr; logic [DATA_W-1:0] data; } mem_exp_t;

    rdy_exp_t  rdy_q[$];
    fill_exp_t fill_q[$];
    mem_exp_t  mem_q[$];

    int vectors = 0;
    int miscompares = 0;
    int rdy_pulses = 0;
    int exp_hits = 0;
    int exp_misses = 0;
    int mem_cnt = 0;
    bit prev_re = 0, prev_we = 0, prev_rdy = 0;
    logic [ADDR_W-1:0] cur_addr = '0;
    logic [DATA_W-1:0] mem_ret_data = '0;
    mem_exp_t mem_cur;

    // Monitor plus memory model, sampled on the falling edge. Checks run
    // first so they see the same mem_rdy the DUT saw at the last rising edge.
    always @(negedge clk) begin
        if (rst) begin
            mem_rdy = 1'b0;
            mem_cnt = 0;
            prev_re = 0;
            prev_we = 0;
            prev_rdy = 0;
        end else begin
            vectors++;
            if ((mem_re && mem_we) || (c_we && c_re) || (cpu_rdy && prev_rdy)) begin
                miscompares++;
                $display("[TB] FAIL strobe_rules: mem_re=%b mem_we=%b c_we=%b c_re=%b rdy_now=%b rdy_prev=%b, required no overlap and single-cycle rdy",
                         mem_re, mem_we, c_we, c_re, cpu_rdy, prev_rdy);
            end
            if (c_re) begin
                vectors++;
                if (c_addr !== cur_addr) begin
                    miscompares++;
                    $display("[TB] FAIL lookup_addr: got %h, expected %h", c_addr, cur_addr);
                end
            end
            if (c_we) begin
                vectors++;
                if (fill_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_fill: addr %h data %h", c_addr, c_wr_data);
                end else begin
                    fill_exp_t f;
                    f = fill_q.pop_front();
                    if (c_addr !== f.addr || c_wr_data !== f.data || c_wdirty !== f.wdirty || c_toggle !== f.toggle) begin
                        miscompares++;
                        $display("[TB] FAIL fill: got addr %h data %h wdirty %b toggle %b, expected addr %h data %h wdirty %b toggle %b",
                                 c_addr, c_wr_data, c_wdirty, c_toggle, f.addr, f.data, f.wdirty, f.toggle);
                    end
                end
            end
            if (cpu_rdy) begin
                rdy_pulses++;
                vectors++;
                if (rdy_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_rdy: cpu_rd_data %h", cpu_rd_data);
                end else begin
                    rdy_exp_t r;
                    r = rdy_q.pop_front();
                    if (r.is_read && cpu_rd_data !== r.data) begin
                        miscompares++;
                        $display("[TB] FAIL read_data: got %h, expected %h", cpu_rd_data, r.data);
                    end
                end
            end
            if ((mem_we && !prev_we) || (mem_re && !prev_re)) begin
                vectors++;
                if (mem_q.size() == 0) begin
                    miscompares++;
                    $display("[TB] FAIL unexpected_mem: re %b we %b addr %h", mem_re, mem_we, mem_addr);
                    mem_cur = '{we: mem_we, addr: mem_addr, data: mem_wr_data};
                end else begin
                    mem_cur = mem_q.pop_front();
                    if (mem_we !== mem_cur.we || mem_addr !== mem_cur.addr ||
                        (mem_cur.we && mem_wr_data !== mem_cur.data)) begin
                        miscompares++;
                        $display("[TB] FAIL mem_request: got we %b addr %h data %h, expected we %b addr %h data %h",
                                 mem_we, mem_addr, mem_wr_data, mem_cur.we, mem_cur.addr, mem_cur.data);
                    end
                end
            end
            // Memory answers in the MEM_WAIT-th cycle of each request.
            if (mem_rdy) begin
                mem_rdy = 1'b0;
                mem_cnt = 0;
            end
            if (mem_re || mem_we) begin
                mem_cnt++;
                if (mem_cnt == MEM_WAIT) begin
                    vectors++;
                    if (mem_addr !== mem_cur.addr || (mem_we && mem_wr_data !== mem_cur.data)) begin
                        miscompares++;
                        $display("[TB] FAIL mem_hold: got addr %h data %h, expected addr %h data %h",
                                 mem_addr, mem_wr_data, mem_cur.addr, mem_cur.data);
                    end
                    mem_rdy     = 1'b1;
                    mem_rd_data = mem_ret_data;
                end
            end
            prev_re  = mem_re;
            prev_we  = mem_we;
            prev_rdy = cpu_rdy;
        end
    end

    task automatic set_array(input bit hit, input bit dirty, input logic [TAG_W-1:0] tag,
                             input logic [DATA_W-1:0] rdata);
        c_hit     = hit;
        c_dirty   = dirty;
        c_tag_out = tag;
        c_rd_data = rdata;
    endtask

    // Drives one request and waits (bounded) for its completion pulse.
    task automatic run_op(input bit re, input bit we, input logic [ADDR_W-1:0] addr,
                          input logic [DATA_W-1:0] wdata, input int exp_lat, input bit hold,
                          input string name);
        int  cycles;
        bit  done;
        cur_addr    = addr;
        cpu_re      = re;
        cpu_we      = we;
        cpu_addr    = addr;
        cpu_wr_data = wdata;
        cycles = 0;
        done   = 0;
        while (!done && cycles < 100) begin
            @(negedge clk);
            cycles++;
            if (cpu_rdy) done = 1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("[TB] FAIL %s_timeout: no cpu_rdy after %0d cycles, expected at %0d", name, cycles, exp_lat);
        end else if (cycles != exp_lat) begin
            miscompares++;
            $display("[TB] FAIL %s_latency: got %0d cycles, expected %0d", name, cycles, exp_lat);
        end
        if (!hold) begin
            cpu_re = 1'b0;
            cpu_we = 1'b0;
        end
    endtask

    task automatic test_counts_and_drain(input string name);
        @(negedge clk);
        #1;
        vectors++;
        if (hit_cnt !== exp_hits[15:0] || miss_cnt !== exp_misses[15:0]) begin
            miscompares++;
            $display("[TB] FAIL %s_counters: got hit %0d miss %0d, expected hit %0d miss %0d",
                     name, hit_cnt, miss_cnt, exp_hits, exp_misses);
        end
        vectors++;
        if (rdy_q.size() != 0 || fill_q.size() != 0 || mem_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL %s_pending: got rdy %0d fill %0d mem %0d outstanding, expected 0",
                     name, rdy_q.size(), fill_q.size(), mem_q.size());
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        cpu_re = 0; cpu_we = 0; cpu_addr = '0; cpu_wr_data = '0;
        set_array(0, 0, '0, '0);
        mem_rdy = 0; mem_rd_data = '0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({c_we, c_re, c_toggle, c_wdirty, mem_re, mem_we, cpu_rdy} !== 7'b0) begin
            miscompares++;
            $display("[TB] FAIL reset_strobes: got %b, expected 0000000",
                     {c_we, c_re, c_toggle, c_wdirty, mem_re, mem_we, cpu_rdy});
        end
        vectors++;
        if (cpu_rd_data !== '0 || c_wr_data !== '0 || mem_wr_data !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_data: got rd %h cwr %h mwr %h, expected 0", cpu_rd_data, c_wr_data, mem_wr_data);
        end
        vectors++;
        if (c_addr !== '0 || mem_addr !== '0 || hit_cnt !== '0 || miss_cnt !== '0) begin
            miscompares++;
            $display("[TB] FAIL reset_addr_cnt: got c_addr %h mem_addr %h hit %0d miss %0d, expected 0",
                     c_addr, mem_addr, hit_cnt, miss_cnt);
        end
        rst = 1'b0;
    endtask

    task automatic test_read_hit;
        set_array(1, 0, '0, 64'hDEAD_BEEF);
        rdy_q.push_back('{1, 64'hDEAD_BEEF});
        run_op(1, 0, 14'h0025, '0, 2, 0, "read_hit");
        exp_hits++;
        test_counts_and_drain("read_hit");
    endtask

    task automatic test_clean_read_miss;
        set_array(0, 0, 9'h0AB, 64'h9999);
        mem_ret_data = 64'h1234;
        mem_q.push_back('{0, 14'h0025, '0});
        fill_q.push_back('{14'h0025, 64'h1234, 0, 1});
        rdy_q.push_back('{1, 64'h1234});
        run_op(1, 0, 14'h0025, '0, 2 + MEM_WAIT + 1, 0, "clean_read_miss");
        exp_misses++;
        test_counts_and_drain("clean_read_miss");
    endtask

    task automatic test_dirty_read_miss;
        set_array(0, 1, 9'h1AB, 64'hAAAA);
        mem_ret_data = 64'h5678;
        mem_q.push_back('{1, {9'h1AB, 5'h05}, 64'hAAAA});
        mem_q.push_back('{0, 14'h0045, '0});
        fill_q.push_back('{14'h0045, 64'h5678, 0, 1});
        rdy_q.push_back('{1, 64'h5678});
        run_op(1, 0, 14'h0045, '0, 2 + 2 * MEM_WAIT + 1, 0, "dirty_read_miss");
        exp_misses++;
        test_counts_and_drain("dirty_read_miss");
    endtask

    task automatic test_writes;
        set_array(1, 0, '0, 64'hFFFF);
        fill_q.push_back('{14'h0033, 64'h55, 1, 0});
        rdy_q.push_back('{0, '0});
        run_op(0, 1, 14'h0033, 64'h55, 3, 0, "write_hit");
        exp_hits++;
        test_counts_and_drain("write_hit");

        set_array(0, 0, 9'h011, 64'hEEEE);
        fill_q.push_back('{14'h0066, 64'h77, 1, 1});
        rdy_q.push_back('{0, '0});
        run_op(0, 1, 14'h0066, 64'h77, 3, 0, "write_miss_clean");
        exp_misses++;
        test_counts_and_drain("write_miss_clean");

        set_array(0, 1, 9'h0F0, 64'hBBBB);
        mem_q.push_back('{1, {9'h0F0, 5'h07}, 64'hBBBB});
        fill_q.push_back('{14'h0107, 64'h99, 1, 1});
        rdy_q.push_back('{0, '0});
        run_op(0, 1, 14'h0107, 64'h99, 2 + MEM_WAIT + 1, 0, "write_miss_dirty");
        exp_misses++;
        test_counts_and_drain("write_miss_dirty");
    endtask

    task automatic test_write_priority;
        set_array(1, 0, '0, 64'h4444);
        fill_q.push_back('{14'h0200, 64'hC0FFEE, 1, 0});
        rdy_q.push_back('{0, '0});
        run_op(1, 1, 14'h0200, 64'hC0FFEE, 3, 0, "write_priority");
        exp_hits++;
        test_counts_and_drain("write_priority");
    endtask

    task automatic test_back_to_back;
        set_array(1, 0, '0, 64'h111);
        rdy_q.push_back('{1, 64'h111});
        run_op(1, 0, 14'h0010, '0, 2, 1, "b2b_first");
        set_array(1, 0, '0, 64'h222);
        rdy_q.push_back('{1, 64'h222});
        run_op(1, 0, 14'h0011, '0, 2, 0, "b2b_second");
        exp_hits += 2;
        test_counts_and_drain("back_to_back");
    endtask

    task automatic test_reset_mid_writeback;
        int waited;
        int pulses_before;
        set_array(0, 1, 9'h1AB, 64'hAAAA);
        mem_q.push_back('{1, {9'h1AB, 5'h05}, 64'hAAAA});
        cur_addr = 14'h0045;
        cpu_addr = 14'h0045;
        cpu_re   = 1'b1;
        waited   = 0;
        while (!mem_we && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        vectors++;
        if (!mem_we) begin
            miscompares++;
            $display("[TB] FAIL rst_wb_reach: mem_we got %b, expected 1 within 20 cycles", mem_we);
        end
        pulses_before = rdy_pulses;
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (mem_we !== 1'b0 || mem_re !== 1'b0 || cpu_rdy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_wb_strobes: got mem_we %b mem_re %b rdy %b, expected 0", mem_we, mem_re, cpu_rdy);
        end
        vectors++;
        if (hit_cnt !== '0 || miss_cnt !== '0) begin
            miscompares++;
            $display("[TB] FAIL rst_wb_counters: got hit %0d miss %0d, expected 0", hit_cnt, miss_cnt);
        end
        cpu_re = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        repeat (10) @(negedge clk);
        vectors++;
        if (rdy_pulses != pulses_before || mem_we !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL rst_wb_quiet: got %0d rdy pulses mem_we %b, expected 0 and 0",
                     rdy_pulses - pulses_before, mem_we);
        end
        test_counts_and_drain("reset_mid_writeback");
    endtask

    task automatic test_saturation;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_hits = 0;
        exp_misses = 0;
        set_array(1, 0, '0, 64'h5A5A);
        for (int i = 0; i < 20; i++) begin
            rdy_q.push_back('{1, 64'h5A5A});
            run_op(1, 0, 14'(i), '0, 2, 0, "sat_hit");
            exp_hits++;
        end
        test_counts_and_drain("saturation_wide");
        vectors++;
        if (s_hit_cnt !== 4'hF || s_miss_cnt !== 4'h0) begin
            miscompares++;
            $display("[TB] FAIL saturation: got hit %h miss %h, expected F and 0", s_hit_cnt, s_miss_cnt);
        end
    endtask

    initial begin
        #1_000_000;
        miscompares++;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        @(negedge clk);
        test_read_hit();
        test_clean_read_miss();
        test_dirty_read_miss();
        test_writes();
        test_write_priority();
        test_back_to_back();
        test_reset_mid_writeback();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
